// File: rtl/cdic_sample_scheduler.sv
// Sector-aligned stereo sample scheduler: start/stop and rate switching at sector boundaries,
// sample FIFO with underrun silence, and per-sector sample-count check. Outputs are registered.
module cdic_sample_scheduler #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 16,
  parameter int SPS37  = 504,
  parameter int SPS44  = 588
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sector_tick,
  input  logic                     sample_tick37,
  input  logic                     sample_tick44,
  input  logic                     cmd_start,
  input  logic                     cmd_stop,
  input  logic                     cmd_rate,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_left,
  input  logic [DATA_W-1:0]        in_right,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_left,
  output logic [DATA_W-1:0]        out_right,
  output logic                     playing,
  output logic                     active_rate,
  output logic                     underrun,
  output logic                     sector_mismatch,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [9:0] CNT_MAX = 10'd1023;
  localparam logic [9:0] SPS37_C = 10'(SPS37);
  localparam logic [9:0] SPS44_C = 10'(SPS44);

  typedef enum logic [1:0] {IDLE, ARMED, PLAYING, STOPPING} state_t;

  state_t              state_q, state_d;
  logic                pend_q, pend_d;
  logic                rate_q, rate_d;
  logic [9:0]          cnt_q, cnt_d;
  logic                mism_q, mism_d;
  logic                out_valid_q, out_valid_d;
  logic                underrun_q, underrun_d;
  logic [DATA_W-1:0]   out_l_q, out_l_d;
  logic [DATA_W-1:0]   out_r_q, out_r_d;
  logic [AW-1:0]       wr_q, wr_d;
  logic [AW-1:0]       rd_q, rd_d;
  logic [LW-1:0]       lvl_q, lvl_d;
  logic [2*DATA_W-1:0] mem_q [DEPTH];

  logic play_en, eff_rate, emit, flush, push, pop;

  assign in_ready        = (lvl_q < LW'(DEPTH));
  assign out_valid       = out_valid_q;
  assign out_left        = out_l_q;
  assign out_right       = out_r_q;
  assign playing         = (state_q == PLAYING) || (state_q == STOPPING);
  assign active_rate     = rate_q;
  assign underrun        = underrun_q;
  assign sector_mismatch = mism_q;
  assign fifo_level      = lvl_q;

  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    rate_d   = rate_q;
    cnt_d    = cnt_q;
    mism_d   = 1'b0;
    flush    = 1'b0;
    play_en  = 1'b0;
    eff_rate = rate_q;

    case (state_q)
      IDLE: begin
        if (cmd_start) begin
          pend_d  = cmd_rate;
          state_d = ARMED;
        end
      end
      ARMED: begin
        if (cmd_stop) begin
          state_d = IDLE;
          flush   = 1'b1;
        end else if (sector_tick) begin
          rate_d   = pend_q;
          eff_rate = pend_q;
          cnt_d    = '0;
          play_en  = 1'b1;
          state_d  = PLAYING;
        end
      end
      PLAYING, STOPPING: begin
        pend_d  = cmd_rate;
        play_en = 1'b1;
        if (state_q == PLAYING && cmd_stop) state_d = STOPPING;
        if (sector_tick) begin
          mism_d = (cnt_q != (rate_q ? SPS44_C : SPS37_C));
          if (state_q == STOPPING) begin
            state_d = IDLE;
            flush   = 1'b1;
            play_en = 1'b0;
          end else begin
            // A coincident sample tick already belongs to the new sector's rate.
            rate_d   = cmd_rate;
            eff_rate = cmd_rate;
            cnt_d    = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    emit = play_en && (eff_rate ? sample_tick44 : sample_tick37);
    if (emit) cnt_d = (cnt_d == CNT_MAX) ? cnt_d : cnt_d + 10'd1;

    push = in_valid && in_ready;
    pop  = emit && (lvl_q != '0);

    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      lvl_d = '0;
    end else begin
      wr_d  = wr_q + AW'(push);
      rd_d  = rd_q + AW'(pop);
      lvl_d = lvl_q + LW'(push) - LW'(pop);
    end

    out_valid_d = emit;
    underrun_d  = emit && !pop;
    out_l_d     = out_l_q;
    out_r_d     = out_r_q;
    if (emit) {out_l_d, out_r_d} = pop ? mem_q[rd_q] : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      pend_q      <= 1'b0;
      rate_q      <= 1'b0;
      cnt_q       <= '0;
      mism_q      <= 1'b0;
      out_valid_q <= 1'b0;
      underrun_q  <= 1'b0;
      out_l_q     <= '0;
      out_r_q     <= '0;
      wr_q        <= '0;
      rd_q        <= '0;
      lvl_q       <= '0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      rate_q      <= rate_d;
      cnt_q       <= cnt_d;
      mism_q      <= mism_d;
      out_valid_q <= out_valid_d;
      underrun_q  <= underrun_d;
      out_l_q     <= out_l_d;
      out_r_q     <= out_r_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      lvl_q       <= lvl_d;
    end
  end

  // Storage needs no reset: pointers and level define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= {in_left, in_right};
  end

endmodule

// File: tb/tb_cdic_sample_scheduler.sv
// Scoreboard bench for cdic_sample_scheduler: expected pairs queued at each selected tick,
// checked by a monitor on out_valid; scenario tasks check levels, state and pulses inline.
module tb_cdic_sample_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sector_tick = 1'b0, sample_tick37 = 1'b0, sample_tick44 = 1'b0;
  logic        cmd_start = 1'b0, cmd_stop = 1'b0, cmd_rate = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic [15:0] in_left = '0, in_right = '0;
  logic        out_valid;
  logic [15:0] out_left, out_right;
  logic        playing, active_rate, underrun, sector_mismatch;
  logic [4:0]  fifo_level;

  typedef struct packed {logic ur; logic [15:0] l; logic [15:0] r;} exp_t;
  exp_t        exp_q[$];
  logic [31:0] mq[$];
  int          n_cmp = 0, n_err = 0, mism_cnt = 0;

  cdic_sample_scheduler dut (
    .clk(clk), .reset(reset), .sector_tick(sector_tick),
    .sample_tick37(sample_tick37), .sample_tick44(sample_tick44),
    .cmd_start(cmd_start), .cmd_stop(cmd_stop), .cmd_rate(cmd_rate),
    .in_valid(in_valid), .in_ready(in_ready), .in_left(in_left), .in_right(in_right),
    .out_valid(out_valid), .out_left(out_left), .out_right(out_right),
    .playing(playing), .active_rate(active_rate), .underrun(underrun),
    .sector_mismatch(sector_mismatch), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (sector_mismatch) mism_cnt++;
    if (underrun && !out_valid) begin
      n_cmp++; n_err++;
      $display("FAIL underrun_without_valid: underrun=1 out_valid=0, required underrun only with out_valid");
    end
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_out_valid: got %h/%h ur=%b, required no output", out_left, out_right, underrun);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        n_cmp++;
        if ({underrun, out_left, out_right} !== e) begin
          n_err++;
          $display("FAIL out_pair: got ur=%b %h/%h, required ur=%b %h/%h",
                   underrun, out_left, out_right, e.ur, e.l, e.r);
        end
      end
    end
  end

  task automatic drive(input bit st, input bit t37, input bit t44, input bit start,
                       input bit stop, input bit vld, input logic [31:0] d = 32'h0);
    sector_tick = st; sample_tick37 = t37; sample_tick44 = t44;
    cmd_start = start; cmd_stop = stop; in_valid = vld; {in_left, in_right} = d;
    @(negedge clk);
    sector_tick = 0; sample_tick37 = 0; sample_tick44 = 0;
    cmd_start = 0; cmd_stop = 0; in_valid = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic push_pair();
    logic [31:0] d;
    d = $urandom;
    mq.push_back(d);
    drive(0, 0, 0, 0, 0, 1, d);
  endtask

  // Selected tick with its expectation, then the other-rate tick which must be ignored.
  task automatic tick_exp(input bit r44);
    exp_t e;
    if (mq.size() > 0) begin e.ur = 1'b0; {e.l, e.r} = mq.pop_front(); end
    else e = {1'b1, 32'h0};
    exp_q.push_back(e);
    drive(0, !r44, r44, 0, 0, 0);
    drive(0, r44, !r44, 0, 0, 0);
  endtask

  task automatic stop_to_idle();
    drive(0, 0, 0, 0, 1, 0);
    drive(1, 0, 0, 0, 0, 0);
    mq.delete();
    idle(2);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if ({out_valid, underrun, sector_mismatch, playing, active_rate} !== 5'b0) begin
      n_err++; $display("FAIL reset_flags: got %b, required 00000",
                        {out_valid, underrun, sector_mismatch, playing, active_rate}); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
    n_cmp++; if (fifo_level !== 5'd0) begin n_err++; $display("FAIL reset_level: got %0d, required 0", fifo_level); end
    n_cmp++; if ({out_left, out_right} !== 32'h0) begin
      n_err++; $display("FAIL reset_data: got %h/%h, required 0/0", out_left, out_right); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_prefill();
    repeat (4) push_pair();
    n_cmp++; if (fifo_level !== 5'd4) begin n_err++; $display("FAIL prefill_level: got %0d, required 4", fifo_level); end
    cmd_rate = 1'b0;
    drive(0, 0, 0, 1, 0, 0);
    idle(100);
    drive(1, 0, 0, 0, 0, 0);
    n_cmp++; if ({playing, active_rate} !== 2'b10) begin
      n_err++; $display("FAIL prefill_playing: got playing=%b rate=%b, required 1/0", playing, active_rate); end
    for (int i = 0; i < 5; i++) begin
      exp_t e;
      if (mq.size() > 0) begin e.ur = 1'b0; {e.l, e.r} = mq.pop_front(); end
      else e = {1'b1, 32'h0};
      exp_q.push_back(e);
      drive(0, 1, 0, 0, 0, 0);
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL prefill_latency[%0d]: got out_valid=%b, required 1", i, out_valid); end
      if (i == 4) begin
        n_cmp++; if (underrun !== 1'b1) begin n_err++; $display("FAIL prefill_underrun: got %b, required 1", underrun); end
      end
      drive(0, 0, 0, 0, 0, 0);
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL prefill_pulse[%0d]: got out_valid=%b, required 0", i, out_valid); end
    end
    stop_to_idle();
    n_cmp++; if (playing !== 1'b0) begin n_err++; $display("FAIL prefill_stopped: got playing=%b, required 0", playing); end
  endtask

  task automatic test_rate_switch();
    cmd_rate = 1'b0;
    drive(0, 0, 0, 1, 0, 0);
    idle(3);
    drive(1, 0, 0, 0, 0, 0);
    idle(2);
    mism_cnt = 0;
    repeat (250) tick_exp(1'b0);
    cmd_rate = 1'b1;
    idle(3);
    n_cmp++; if (active_rate !== 1'b0) begin n_err++; $display("FAIL rate_mid_sector: got %b, required 0", active_rate); end
    repeat (254) tick_exp(1'b0);
    drive(1, 0, 0, 0, 0, 0);
    n_cmp++; if (active_rate !== 1'b1) begin n_err++; $display("FAIL rate_applied: got %b, required 1", active_rate); end
    repeat (588) tick_exp(1'b1);
    drive(1, 0, 0, 0, 0, 0);
    idle(2);
    n_cmp++; if (mism_cnt !== 0) begin n_err++; $display("FAIL rate_no_mismatch: got %0d pulses, required 0", mism_cnt); end
    n_cmp++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL rate_outputs: %0d outputs missing, required 0", exp_q.size()); end
    cmd_rate = 1'b0;
    stop_to_idle();
  endtask

  task automatic test_mismatch();
    cmd_rate = 1'b0;
    drive(0, 0, 0, 1, 0, 0);
    idle(2);
    drive(1, 0, 0, 0, 0, 0);
    repeat (504) tick_exp(1'b0);
    drive(1, 0, 0, 0, 0, 0);
    idle(2);
    mism_cnt = 0;
    idle(1);
    repeat (503) tick_exp(1'b0);
    drive(1, 0, 0, 0, 0, 0);
    n_cmp++; if (sector_mismatch !== 1'b1) begin n_err++; $display("FAIL mismatch_pulse: got %b, required 1", sector_mismatch); end
    drive(0, 0, 0, 0, 0, 0);
    n_cmp++; if (sector_mismatch !== 1'b0) begin n_err++; $display("FAIL mismatch_width: got %b, required 0", sector_mismatch); end
    idle(2);
    n_cmp++; if (mism_cnt !== 1) begin n_err++; $display("FAIL mismatch_count: got %0d, required 1", mism_cnt); end
    stop_to_idle();
  endtask

  task automatic test_stop();
    cmd_rate = 1'b0;
    drive(0, 0, 0, 1, 0, 0);
    idle(2);
    exp_q.push_back({1'b1, 32'h0});
    drive(1, 1, 0, 0, 0, 0);
    n_cmp++; if ({out_valid, underrun} !== 2'b11) begin
      n_err++; $display("FAIL arm_coincident: got valid=%b ur=%b, required 1/1", out_valid, underrun); end
    repeat (8) push_pair();
    n_cmp++; if (fifo_level !== 5'd8) begin n_err++; $display("FAIL stop_level8: got %0d, required 8", fifo_level); end
    drive(0, 0, 0, 0, 1, 0);
    n_cmp++; if (playing !== 1'b1) begin n_err++; $display("FAIL stopping_playing: got %b, required 1", playing); end
    repeat (3) tick_exp(1'b0);
    n_cmp++; if (fifo_level !== 5'd5) begin n_err++; $display("FAIL stopping_drain: got %0d, required 5", fifo_level); end
    drive(1, 1, 0, 0, 0, 1, 32'hdead_beef);
    mq.delete();
    n_cmp++; if ({out_valid, playing} !== 2'b00) begin
      n_err++; $display("FAIL stop_boundary: got valid=%b playing=%b, required 0/0", out_valid, playing); end
    n_cmp++; if (fifo_level !== 5'd0) begin n_err++; $display("FAIL stop_flush: got %0d, required 0", fifo_level); end
    drive(0, 1, 0, 0, 0, 0);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL idle_tick: got out_valid=%b, required 0", out_valid); end
    idle(2);
  endtask

  task automatic test_full();
    exp_t e;
    repeat (16) push_pair();
    n_cmp++; if ({fifo_level, in_ready} !== {5'd16, 1'b0}) begin
      n_err++; $display("FAIL full_level: got %0d rdy=%b, required 16/0", fifo_level, in_ready); end
    cmd_rate = 1'b0;
    drive(0, 0, 0, 1, 0, 0);
    idle(2);
    drive(1, 0, 0, 0, 0, 0);
    e.ur = 1'b0; {e.l, e.r} = mq.pop_front(); exp_q.push_back(e);
    drive(0, 1, 0, 0, 0, 1, 32'h1111_2222);
    n_cmp++; if ({fifo_level, in_ready} !== {5'd15, 1'b1}) begin
      n_err++; $display("FAIL full_pop_no_push: got %0d rdy=%b, required 15/1", fifo_level, in_ready); end
    e.ur = 1'b0; {e.l, e.r} = mq.pop_front(); exp_q.push_back(e);
    mq.push_back(32'h3333_4444);
    drive(0, 1, 0, 0, 0, 1, 32'h3333_4444);
    n_cmp++; if ({fifo_level, in_ready} !== {5'd15, 1'b1}) begin
      n_err++; $display("FAIL push_pop_15: got %0d rdy=%b, required 15/1", fifo_level, in_ready); end
    repeat (15) tick_exp(1'b0);
    n_cmp++; if (fifo_level !== 5'd0) begin n_err++; $display("FAIL full_drain: got %0d, required 0", fifo_level); end
    stop_to_idle();
  endtask

  task automatic test_reset_mid();
    cmd_rate = 1'b1;
    drive(0, 0, 0, 1, 0, 0);
    idle(2);
    drive(1, 0, 0, 0, 0, 0);
    repeat (2) push_pair();
    n_cmp++; if ({playing, active_rate, fifo_level} !== {2'b11, 5'd2}) begin
      n_err++; $display("FAIL pre_reset: got p=%b r=%b lvl=%0d, required 1/1/2", playing, active_rate, fifo_level); end
    sample_tick44 = 1'b1;
    #2 reset = 1'b1;
    #1;
    mq.delete();
    n_cmp++; if ({out_valid, playing, active_rate, fifo_level, in_ready} !== {3'b000, 5'd0, 1'b1}) begin
      n_err++; $display("FAIL async_reset: got v=%b p=%b r=%b lvl=%0d rdy=%b, required 0/0/0/0/1",
                        out_valid, playing, active_rate, fifo_level, in_ready); end
    @(negedge clk);
    sample_tick44 = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_no_valid: got %b, required 0", out_valid); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    cmd_rate = 1'b0;
    drive(0, 1, 1, 0, 0, 0);
    n_cmp++; if ({out_valid, playing} !== 2'b00) begin
      n_err++; $display("FAIL post_reset_idle: got v=%b p=%b, required 0/0", out_valid, playing); end
  endtask

  initial begin
    test_reset();
    test_prefill();
    test_rate_switch();
    test_mismatch();
    test_stop();
    test_full();
    test_reset_mid();
    idle(3);
    n_cmp++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL outputs_missing: %0d outstanding, required 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cdic_sample_scheduler.md
Name: cdic_sample_scheduler

Overview:
- Sequences stereo audio playback from the CDIC decoder onto the 37.8 kHz and 44.1 kHz sample ticks, aligned to the 75 Hz sector tick.
- All input ticks are single-cycle pulses already in the `clk` domain.
- Sits between the ADPCM/PCM decoder, which pushes sample pairs, and the audio output mixer, which receives one pair per selected tick.
- Owns start/stop and rate switching at sector boundaries, a small sample FIFO, underrun handling and a per-sector sample-count check.

Parameters:
- DEPTH, 16, FIFO depth in stereo pairs; power of two, at least 4.
- DATA_W, 16, width of each channel sample; two's complement.
- SPS37, 504, expected samples per sector at 37.8 kHz.
- SPS44, 588, expected samples per sector at 44.1 kHz.

Ports:
- clk  in  1  system clock, single clock domain.
- reset  in  1  asynchronous, active-high reset.
- sector_tick  in  1  1-cycle pulse at 75 Hz.
- sample_tick37  in  1  1-cycle pulse at 37.8 kHz.
- sample_tick44  in  1  1-cycle pulse at 44.1 kHz.
- cmd_start  in  1  1-cycle request to start playback.
- cmd_stop  in  1  1-cycle request to stop playback.
- cmd_rate  in  1  rate sampled with cmd_start or while playing: 0 = 37.8 kHz, 1 = 44.1 kHz.
- in_valid  in  1  input pair valid.
- in_ready  out  1  FIFO can accept a pair.
- in_left  in  DATA_W  left sample.
- in_right  in  DATA_W  right sample.
- out_valid  out  1  1-cycle pulse, output pair is presented.
- out_left  out  DATA_W  left output sample.
- out_right  out  DATA_W  right output sample.
- playing  out  1  high in PLAYING or STOPPING.
- active_rate  out  1  rate currently in effect.
- underrun  out  1  1-cycle pulse, a tick found the FIFO empty.
- sector_mismatch  out  1  1-cycle pulse, sample count at a sector boundary was wrong.
- fifo_level  out  $clog2(DEPTH)+1  number of occupied FIFO entries.

Behaviour:
- Reset values:
  - All outputs 0, except in_ready = 1.
  - FIFO empty, state IDLE, active_rate 0, pending rate 0, sector sample counter 0.
- States: IDLE, ARMED, PLAYING, STOPPING.
- IDLE:
  - cmd_start latches cmd_rate into pending_rate and moves to ARMED.
  - cmd_stop is ignored.
- ARMED:
  - On sector_tick: active_rate <= pending_rate, sample counter cleared, move to PLAYING.
  - cmd_stop without a coincident sector_tick: go to IDLE and flush the FIFO.
  - cmd_stop with a coincident sector_tick: stop wins; go to IDLE and flush the FIFO.
- PLAYING:
  - The selected tick is sample_tick37 when active_rate = 0, sample_tick44 otherwise. The other tick is ignored.
  - cmd_rate is captured into pending_rate every cycle. It is applied only at sector_tick, never mid-sector.
  - cmd_stop moves to STOPPING.
  - cmd_start is ignored.
- STOPPING:
  - Continues playing exactly as PLAYING until the next sector_tick.
  - At that sector_tick: go to IDLE, flush the FIFO. No sample is emitted in that cycle.
- Sector boundary in PLAYING (sector_tick):
  - Compare the counter to SPS37 or SPS44 for the outgoing active_rate. If unequal, pulse sector_mismatch in the following cycle.
  - Skip the check on the first sector_tick after ARMED.
  - Then apply pending_rate and clear the counter.
- Coincident sector_tick and sample tick:
  - The sample belongs to the new sector and uses the rate in effect after the update.
  - The counter restarts at 1.
  - ARMED to PLAYING with a coincident tick of the newly applied rate emits a sample in that same cycle's evaluation.
- Sample emission, when a selected tick fires in PLAYING or STOPPING:
  - Registered, 1-cycle latency: out_valid is high in the next cycle.
  - FIFO non-empty: pop the head; out_left/out_right = head pair.
  - FIFO empty: out_left = out_right = 0 (silence), out_valid still pulses, underrun pulses in the same cycle as out_valid.
  - The counter increments in both cases. Width is 10 bits, saturating at 1023.
- out_left/out_right hold their value between out_valid pulses.
- FIFO:
  - in_ready = (fifo_level < DEPTH). A push occurs when in_valid && in_ready.
  - Simultaneous push and pop: the level is unchanged and ordering is preserved.
  - When full, in_ready is low even if a pop happens in the same cycle.
  - Pushes are accepted in every state, so IDLE pre-fill is allowed. A flush discards pushes made in the flush cycle.
  - Read and write pointers wrap modulo DEPTH.
- Reset mid-operation: immediate return to reset values and the FIFO is emptied. No out_valid appears after reset asserts.

Test Plan:
- Pre-fill 4 pairs in IDLE, cmd_start rate=0, sector_tick after 100 cycles, then sample_tick37 pulses → first out_valid 1 cycle after the first tick following the sector_tick; the 4 pairs come out in push order with no underrun; the 5th tick gives out_valid with 0/0 and an underrun pulse.
- PLAYING at 37.8 kHz with 504 ticks per sector, then cmd_rate=1 mid-sector → rate stays 0 until the next sector_tick; afterwards only sample_tick44 produces output; no sector_mismatch at either boundary when counts are 504 then 588.
- Deliver 503 sample_tick37 pulses between two sector_ticks while PLAYING → exactly one sector_mismatch pulse, one cycle after the second sector_tick.
- cmd_stop mid-sector with the FIFO at 8 entries → output continues until the sector_tick; then IDLE, playing = 0, fifo_level = 0, no out_valid in the boundary cycle.
- Fill the FIFO to DEPTH=16 → in_ready = 0; with in_valid and a pop in the same cycle, no push occurs and the level becomes 15; then push and pop simultaneously at level 15 → level stays 15 and in_ready = 1.
- Assert reset asynchronously between a sample tick and its out_valid → out_valid never rises, all outputs return to reset values immediately, and in_ready = 1.
